// File: rtl/cacheline_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter_pkg
// Description : Shared constants, FSM state type and address helper for the
//               cache-line to burst-memory adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package cacheline_adapter_pkg;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int BURST_LEN  = 4;
  localparam int OFFSET_W   = 5;
  localparam int BEAT_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Clears the byte-offset bits so the burst always starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~((32'd1 << OFFSET_W) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cacheline_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter_if / cacheline_burst_if
// Description : Cache-side line interface and memory-side burst interface.
//               master = initiator of requests, slave = responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface cacheline_adapter_if;
  import cacheline_adapter_pkg::*;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

interface cacheline_burst_if;
  import cacheline_adapter_pkg::*;

  logic [31:0]       burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  modport master (
    output burst_address, burst_read, burst_write, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport slave (
    input  burst_address, burst_read, burst_write, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_adapter_line_beat_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_beat_buffer
// Description : 256-bit line register with whole-line load, beat-indexed
//               64-bit load and beat-indexed 64-bit select.
// Revision    : 1.0 - initial release
// ============================================================================
module line_beat_buffer
  import cacheline_adapter_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_load_line,
  input  wire logic [LINE_W-1:0]     i_line,
  input  wire logic                  i_load_beat,
  input  wire logic [BEAT_IDX_W-1:0] i_beat_idx,
  input  wire logic [BEAT_W-1:0]     i_beat,
  input  wire logic [BEAT_IDX_W-1:0] i_sel_idx,
  output logic      [BEAT_W-1:0]     o_sel_beat,
  output logic      [LINE_W-1:0]     o_line
);

  logic [LINE_W-1:0] r_line;

  // Line storage: a whole-line load takes priority; the adapter never asks for both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_load_line) begin
      r_line <= i_line;
    end else if (i_load_beat) begin
      r_line[i_beat_idx*BEAT_W +: BEAT_W] <= i_beat;
    end
  end

  assign o_sel_beat = r_line[i_sel_idx*BEAT_W +: BEAT_W];
  assign o_line     = r_line;

endmodule
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter
// Description : Accepts one 256-bit line read/write from a cache and moves it
//               as a 4-beat 64-bit burst to memory, then pulses pmem_resp.
//               Optional macro CACHELINE_ADAPTER_EARLY_RESP_EN removes the
//               DONE cycle and responds combinationally on the final beat.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adapter #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  cacheline_adapter_if.slave  pmem,
  cacheline_burst_if.master   burst
);
  import cacheline_adapter_pkg::*;

  localparam logic [BEAT_IDX_W-1:0] c_last_beat = BEAT_IDX_W'(BURST_LEN - 1);

  state_e                  r_state;
  logic [BEAT_IDX_W-1:0]   r_beat;
  logic                    r_burst_read;
  logic                    r_burst_write;
  logic [31:0]             r_address;
  logic [LINE_W-1:0]       r_rdata;
`ifndef CACHELINE_ADAPTER_EARLY_RESP_EN
  logic                    r_resp;
`endif

  logic                    w_final_beat;
  logic                    w_load_line;
  logic                    w_load_beat;
  logic [BEAT_W-1:0]       w_sel_beat;
  logic [LINE_W-1:0]       w_buf_line;
  logic [LINE_W-1:0]       w_full_line;

  assign w_final_beat = ((r_state == RD) || (r_state == WR)) &&
                        burst.burst_resp && (r_beat == c_last_beat);
  assign w_load_line  = (r_state == IDLE) && pmem.pmem_write;
  assign w_load_beat  = (r_state == RD) && burst.burst_resp;

  line_beat_buffer u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load_line (w_load_line),
    .i_line      (pmem.pmem_wdata),
    .i_load_beat (w_load_beat),
    .i_beat_idx  (r_beat),
    .i_beat      (burst.burst_rdata),
    .i_sel_idx   (r_beat),
    .o_sel_beat  (w_sel_beat),
    .o_line      (w_buf_line)
  );

  // Completed read line: three buffered beats with the in-flight last beat on top.
  always_comb begin
    w_full_line                          = w_buf_line;
    w_full_line[LINE_W-1 -: BEAT_W]      = burst.burst_rdata;
  end

  // Request FSM, beat counter and registered burst/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_burst_read  <= 1'b0;
      r_burst_write <= 1'b0;
      r_address     <= '0;
      r_rdata       <= '0;
`ifndef CACHELINE_ADAPTER_EARLY_RESP_EN
      r_resp        <= 1'b0;
`endif
    end else begin
`ifndef CACHELINE_ADAPTER_EARLY_RESP_EN
      r_resp <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // Write wins when both requests are present.
          if (pmem.pmem_write) begin
            r_address     <= line_align(pmem.pmem_address);
            r_beat        <= '0;
            r_burst_write <= 1'b1;
            r_state       <= WR;
          end else if (pmem.pmem_read) begin
            r_address     <= line_align(pmem.pmem_address);
            r_beat        <= '0;
            r_burst_read  <= 1'b1;
            r_state       <= RD;
          end
        end
        RD: begin
          if (burst.burst_resp) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == c_last_beat) begin
              r_rdata      <= w_full_line;
              r_burst_read <= 1'b0;
`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
              r_state      <= IDLE;
`else
              r_resp       <= 1'b1;
              r_state      <= DONE;
`endif
            end
          end
        end
        WR: begin
          if (burst.burst_resp) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == c_last_beat) begin
              r_burst_write <= 1'b0;
`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
              r_state       <= IDLE;
`else
              r_resp        <= 1'b1;
              r_state       <= DONE;
`endif
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign burst.burst_address = r_address;
  assign burst.burst_read    = r_burst_read;
  assign burst.burst_write   = r_burst_write;
  // Write beats only appear on the bus while a write burst is active.
  assign burst.burst_wdata   = (r_state == WR) ? w_sel_beat : '0;

`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
  assign pmem.pmem_resp  = w_final_beat;
  assign pmem.pmem_rdata = (w_final_beat && (r_state == RD)) ? w_full_line : r_rdata;
`else
  assign pmem.pmem_resp  = r_resp;
  assign pmem.pmem_rdata = r_rdata;
  // Only the early-response build consumes the combinational final-beat term.
  logic w_final_beat_unused;
  assign w_final_beat_unused = w_final_beat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adapter
// Description : Directed bench for cacheline_adapter with a transaction-level
//               timing/data model and a per-cycle output comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;

`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [255:0] L1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
  localparam logic [255:0] LW = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
  localparam logic [255:0] L3 = 256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0;
  localparam logic [255:0] L4 = 256'hDEADBEEF00000004_DEADBEEF00000003_DEADBEEF00000002_DEADBEEF00000001;
  localparam logic [255:0] L5 = 256'h5555555555555555_6666666666666666_7777777777777777_8888888888888888;
  localparam logic [255:0] L6 = 256'hCAFEBABE00000004_CAFEBABE00000003_CAFEBABE00000002_CAFEBABE00000001;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  cacheline_adapter_if pmem_bus ();
  cacheline_burst_if   burst_bus ();

  cacheline_adapter dut (
    .clk   (clk),
    .rst   (rst),
    .pmem  (pmem_bus),
    .burst (burst_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the current transaction: acceptance period and the periods in
  // which memory acknowledges each beat; everything else follows from these.
  bit           m_valid = 1'b0;
  bit           m_wr = 1'b0;
  int           m_a = 0;
  int           m_ack [4] = '{0, 0, 0, 0};
  logic [255:0] m_line = '0;
  logic [31:0]  m_addr = '0;
  logic [31:0]  m_prev_addr = '0;
  logic [255:0] m_prev_rdata = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Per-cycle comparator, sampling after the bench drives inputs at negedge.
  bit           e_win;
  int           e_resp_p;
  int           e_nb;
  logic [31:0]  e_addr;
  logic [255:0] e_rdata;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      e_win    = m_valid && (cyc >= m_a) && (cyc <= m_ack[3]);
      e_resp_p = m_ack[3] + (EARLY ? 0 : 1);
      e_addr   = (m_valid && cyc >= m_a) ? m_addr : m_prev_addr;
      e_rdata  = (m_valid && !m_wr && cyc >= e_resp_p) ? m_line : m_prev_rdata;
      chk("burst_read",    {255'd0, burst_bus.burst_read},  {255'd0, e_win && !m_wr});
      chk("burst_write",   {255'd0, burst_bus.burst_write}, {255'd0, e_win && m_wr});
      chk("pmem_resp",     {255'd0, pmem_bus.pmem_resp},    {255'd0, m_valid && (cyc == e_resp_p)});
      chk("burst_address", {224'd0, burst_bus.burst_address}, {224'd0, e_addr});
      chk("pmem_rdata",    pmem_bus.pmem_rdata, e_rdata);
      if (e_win && m_wr) begin
        e_nb = 0;
        for (int k = 0; k < 4; k++) if (m_ack[k] < cyc) e_nb++;
        chk("burst_wdata", {192'd0, burst_bus.burst_wdata}, {192'd0, m_line[e_nb*64 +: 64]});
      end
    end
  end

  // Runs one request; called at a negedge. gN = idle cycles before beat N.
  // abort_at >= 0 replaces that beat's acknowledge with a reset.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] line, input int g0, input int g1,
                         input int g2, input int g3, input int abort_at,
                         output int lat, output logic [255:0] rdata_at_resp,
                         output logic [63:0] top_fwd, output bit saw_rd);
    int gaps [4];
    int nacked;
    bit done;
    gaps = '{g0, g1, g2, g3};
    if (m_valid) begin
      m_prev_addr = m_addr;
      if (!m_wr) m_prev_rdata = m_line;
    end
    m_wr     = wr;
    m_line   = line;
    m_addr   = {addr[31:5], 5'b0};
    m_a      = cyc + 1;
    m_ack[0] = m_a + gaps[0];
    for (int k = 1; k < 4; k++) m_ack[k] = m_ack[k-1] + 1 + gaps[k];
    m_valid  = 1'b1;
    pmem_bus.pmem_read    = rd;
    pmem_bus.pmem_write   = wr;
    pmem_bus.pmem_address = addr;
    pmem_bus.pmem_wdata   = wr ? line : rand256();
    lat = -1; nacked = 0; done = 1'b0; saw_rd = 1'b0;
    rdata_at_resp = '0; top_fwd = '0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      pmem_bus.pmem_wdata = rand256();
      if (abort_at >= 0 && nacked == abort_at && cyc == m_ack[nacked]) begin
        burst_bus.burst_resp = 1'b0;
        pmem_bus.pmem_read   = 1'b0;
        pmem_bus.pmem_write  = 1'b0;
        rst = 1'b1;
        m_valid = 1'b0; m_prev_addr = '0; m_prev_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        done = 1'b1;
      end else begin
        if (nacked < 4 && cyc == m_ack[nacked]) begin
          burst_bus.burst_resp  = 1'b1;
          burst_bus.burst_rdata = line[nacked*64 +: 64];
          nacked++;
        end else begin
          burst_bus.burst_resp  = 1'b0;
          burst_bus.burst_rdata = {$urandom, $urandom};
        end
        #2;
        if (burst_bus.burst_read) saw_rd = 1'b1;
        if (pmem_bus.pmem_resp) begin
          lat           = cyc - m_a;
          rdata_at_resp = pmem_bus.pmem_rdata;
          top_fwd       = burst_bus.burst_rdata;
          pmem_bus.pmem_read  = 1'b0;
          pmem_bus.pmem_write = 1'b0;
          done = 1'b1;
        end
      end
    end
    chk("txn_completed", {255'd0, done}, {255'd0, 1'b1});
    @(negedge clk);
    burst_bus.burst_resp = 1'b0;
  endtask

  int           lat;
  logic [255:0] rdat;
  logic [63:0]  fwd;
  bit           saw_rd;

  initial begin
    rst = 1'b1;
    pmem_bus.pmem_read    = 1'b0;
    pmem_bus.pmem_write   = 1'b0;
    pmem_bus.pmem_address = '0;
    pmem_bus.pmem_wdata   = '0;
    burst_bus.burst_rdata = '0;
    burst_bus.burst_resp  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset_resp",  {255'd0, pmem_bus.pmem_resp}, 256'd0);
    chk("reset_addr",  {224'd0, burst_bus.burst_address}, 256'd0);
    chk("reset_rdata", pmem_bus.pmem_rdata, 256'd0);

    // Zero-wait read: response in cycle 5 (cycle 4 with early response).
    @(negedge clk);
    run_txn(1, 0, 32'h0000_1234, L1, 0, 0, 0, 0, -1, lat, rdat, fwd, saw_rd);
    chk("rd0_latency", lat, EARLY ? 3 : 4);
    chk("rd0_line", rdat, L1);
    chk("rd0_addr", {224'd0, burst_bus.burst_address}, {224'd0, 32'h0000_1220});
`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
    chk("rd0_forward_top", {192'd0, rdat[255:192]}, {192'd0, fwd});
`endif

    // Write with ack gaps 0,3,0,2: response 10 cycles after acceptance.
    run_txn(0, 1, 32'hABCD_EF7F, LW, 0, 3, 0, 2, -1, lat, rdat, fwd, saw_rd);
    chk("wr_latency", lat, EARLY ? 8 : 9);
    chk("wr_no_read", {255'd0, saw_rd}, 256'd0);
    chk("wr_addr", {224'd0, burst_bus.burst_address}, {224'd0, 32'hABCD_EF60});

    // Both requests together: write only, read data untouched.
    run_txn(1, 1, 32'h0000_4000, L3, 0, 0, 0, 0, -1, lat, rdat, fwd, saw_rd);
    chk("both_no_read", {255'd0, saw_rd}, 256'd0);
    chk("both_latency", lat, EARLY ? 3 : 4);
    chk("both_rdata_held", pmem_bus.pmem_rdata, L1);

    // Reset in place of the third beat of a stalled read.
    run_txn(1, 0, 32'h0000_8888, L4, 1, 0, 2, 0, 2, lat, rdat, fwd, saw_rd);
    chk("abort_no_resp", lat, -1);
    chk("abort_burst_read",  {255'd0, burst_bus.burst_read},  256'd0);
    chk("abort_burst_write", {255'd0, burst_bus.burst_write}, 256'd0);
    chk("abort_addr",  {224'd0, burst_bus.burst_address}, 256'd0);
    chk("abort_rdata", pmem_bus.pmem_rdata, 256'd0);

    // Read after abort returns the full new line.
    run_txn(1, 0, 32'h0000_8888, L5, 0, 0, 0, 0, -1, lat, rdat, fwd, saw_rd);
    chk("post_abort_latency", lat, EARLY ? 3 : 4);
    chk("post_abort_line", rdat, L5);

    // Spurious acknowledges in IDLE must not move the beat count.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      burst_bus.burst_resp  = 1'b1;
      burst_bus.burst_rdata = {$urandom, $urandom};
    end
    @(negedge clk);
    burst_bus.burst_resp = 1'b0;
    run_txn(1, 0, 32'h1000_003F, L6, 2, 0, 0, 1, -1, lat, rdat, fwd, saw_rd);
    chk("spur_latency", lat, EARLY ? 6 : 7);
    chk("spur_line", rdat, L6);
    chk("spur_addr", {224'd0, burst_bus.burst_address}, {224'd0, 32'h1000_0020});

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cacheline_adapter.md
# cacheline_adapter

Responder on the cache-side physical-memory interface: accepts one 256-bit line read or write from a cache, moves it as a 4-beat, 64-bit burst to main memory, and returns a single-cycle `pmem_resp`. It sits between the data or instruction cache and the burst memory/arbiter. It owns line buffering, beat counting and address alignment.

## Interface
- `BEAT_W`, 64: burst data width in bits.
- `BURST_LEN`, 4: beats per line; `BEAT_W*BURST_LEN` must equal 256.
- `clk`  in  1  clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `pmem_read`  in  1  line read request; held until `pmem_resp`.
- `pmem_write`  in  1  line write request; held until `pmem_resp`.
- `pmem_address`  in  32  line address; bits [4:0] are ignored.
- `pmem_wdata`  in  256  write line; sampled at acceptance.
- `pmem_rdata`  out  256  read line; valid when `pmem_resp` is high, held until the next read completes.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `burst_address`  out  32  `{pmem_address[31:5], 5'b0}`, held for the whole burst.
- `burst_read`  out  1  burst read command.
- `burst_write`  out  1  burst write command.
- `burst_wdata`  out  64  current write beat.
- `burst_rdata`  in  64  current read beat; valid when `burst_resp` is high.
- `burst_resp`  in  1  per-beat acknowledge from memory.

## Operation
- States:
  - IDLE
  - RD: read burst in progress.
  - WR: write burst in progress.
  - DONE: response cycle.
- IDLE:
  - `pmem_write` high: latch the address and `pmem_wdata`, clear the beat count, go to WR.
  - Else `pmem_read` high: latch the address, clear the beat count, go to RD.
  - Write wins if both requests are high.
- RD:
  - `burst_read` is high.
  - On each `burst_resp`, store `burst_rdata` into line bits `[64*k +: 64]`, where k is the beat count, then increment k.
  - On the beat with k==3, go to DONE.
- WR:
  - `burst_write` is high and `burst_wdata` is line slice k.
  - Each `burst_resp` increments k.
  - On the beat with k==3, go to DONE.
- Beat count is 2 bits and wraps 3->0 on the final beat.
- DONE: `pmem_resp` is high for exactly one cycle, then go to IDLE.
- `burst_resp` is ignored in IDLE and DONE.
- Stalls between beats are unbounded; the command and address stay stable.
- Requests seen in DONE are not accepted. The requester drops its request in the cycle after `pmem_resp`, so IDLE never re-accepts a finished request.
- Reset, including mid-burst:
  - State returns to IDLE and the beat count clears.
  - `burst_read`, `burst_write`, `pmem_resp`, `burst_address`, `burst_wdata` and `pmem_rdata` all go to 0.
  - No partial response is issued, and an aborted line is not written into `pmem_rdata`.

## Timing
- All outputs are registered or Moore-decoded from state.
- A request sampled in IDLE at edge 0 raises `burst_read`/`burst_write` in cycle 1.
- With `burst_resp` high every cycle from cycle 1, beats land in cycles 1–4 and `pmem_resp` is in cycle 5.
  - Latency = 1 + beats + 1 cycles.
  - With wait states, latency = 2 + sum of beat latencies.
- `pmem_rdata` updates at the edge that enters DONE and holds the complete line in the `pmem_resp` cycle.
- Back-to-back: the next request can be accepted in the cycle after DONE.

## Configuration
- `CACHELINE_ADAPTER_EARLY_RESP_EN`:
  - Defined: DONE is removed.
  - `pmem_resp` is asserted combinationally in the final-beat cycle (k==3 && `burst_resp`).
  - In that cycle, `pmem_rdata` is the three buffered beats plus `burst_rdata` forwarded as the top slice.
  - The FSM returns to IDLE on that edge. Latency drops by 1.
- Undefined: registered response via DONE, as above.

## Structure
- The shared cache package holds:
  - the state enum typedef (IDLE/RD/WR/DONE);
  - constants `LINE_W`=256, `BEAT_W`=64, `BURST_LEN`=4, `OFFSET_W`=5.
- One sub-module, `line_beat_buffer`: a 256-bit register with a whole-line load (write data), a beat-indexed 64-bit load (read beats) and a beat-indexed 64-bit select (write beats).
- FSM and counter stay in the top module.

## Test plan
- Read, zero wait: `pmem_read`, address 0x0000_1234, beats 0x11..11 to 0x44..44 on consecutive cycles:
  - `burst_address`=0x0000_1220;
  - `pmem_rdata`={0x44..,0x33..,0x22..,0x11..};
  - `pmem_resp` in cycle 5 for exactly 1 cycle.
- Write with stalls: `pmem_write`, line with slices A,B,C,D, and `burst_resp` gaps of 0,3,0,2 cycles:
  - `burst_wdata` shows A,B,C,D in order, each held until its ack;
  - `pmem_resp` arrives 10 cycles after acceptance.
- Simultaneous `pmem_read` and `pmem_write` in IDLE -> a write burst only; `burst_read` never asserts.
- `rst` asserted after beat 2 of a read:
  - the next cycle is IDLE with all outputs 0 and no `pmem_resp`;
  - a following read returns the correct full line.
- Spurious `burst_resp` in IDLE for 5 cycles -> no state change and the beat count stays 0.
- With `CACHELINE_ADAPTER_EARLY_RESP_EN`, the zero-wait read:
  - `pmem_resp` in cycle 4;
  - the `pmem_rdata` top slice equals `burst_rdata` in that cycle.
